// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked round-robin sharing of one UART transmitter,
// with an optional source-ID header byte and a mid-packet stall watchdog.
module uart_tx_arbiter #(
  parameter int                NUM_REQ  = 4,
  parameter int                DATA_W   = 8,
  parameter bit                HDR_EN   = 1'b1,
  parameter logic [DATA_W-1:0] HDR_BASE = 'hA0,
  parameter int                TIMEOUT  = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_valid,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_ready,
  output logic                      busy,
  output logic [2:0]                grant_id,
  output logic                      abort
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d, win, g;
  logic [2:0] grant_id_q, grant_id_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic found;
  assign g = grant_id_q[GW-1:0];
  assign busy = state_q != IDLE;
  assign grant_id = grant_id_q;
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[GW'((int'(rr_ptr_q) + k) % NUM_REQ)]) begin
        found = 1'b1;
        win = GW'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_id_d = grant_id_q;
    stall_cnt_d = stall_cnt_q;
    req_ready = '0;
    tx_valid = 1'b0;
    tx_data = '0;
    abort = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        state_d = HDR_EN ? HDR : DATA;
        grant_id_d = 3'(win);
        rr_ptr_d = GW'((int'(win) + 1) % NUM_REQ);
        stall_cnt_d = '0;
      end
      HDR: begin
        tx_valid = 1'b1;
        tx_data = HDR_BASE | DATA_W'(grant_id_q);
        state_d = tx_ready ? DATA : HDR;
      end
      DATA: begin
        tx_valid = req_valid[g];
        tx_data = req_data[int'(g)*DATA_W +: DATA_W];
        req_ready[g] = tx_ready;
        if (req_valid[g] && tx_ready) begin
          stall_cnt_d = '0;
          state_d = req_last[g] ? IDLE : DATA;
        end else if (tx_ready && TIMEOUT != 0) begin
          // only requester-side stalls count; a busy transmitter is not the owner's fault
          abort = stall_cnt_q == CW'(TIMEOUT - 1);
          state_d = abort ? IDLE : DATA;
          stall_cnt_d = abort ? '0 : stall_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      grant_id_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenario tasks for the round-robin UART transmit arbiter.
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] req_valid = '0, req_last = '0, req_ready;
  logic [31:0] req_data = '0;
  logic tx_valid, busy, abort;
  logic tx_ready = 1'b1;
  logic [7:0] tx_data;
  logic [2:0] grant_id;
  int n_tests = 0, n_fail = 0;
  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .HDR_EN(1'b1), .HDR_BASE(8'hA0), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .busy(busy), .grant_id(grant_id), .abort(abort)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    tx_ready = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask
  task automatic test_reset;
    tick;
    req_valid = 4'hF;
    req_last = 4'hF;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({req_ready, tx_valid, tx_data, busy, grant_id, abort} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_async: got %h expected %h", {req_ready, tx_valid, tx_data, busy, grant_id, abort}, 18'h0);
    end
    tick;
    n_tests++;
    if ({req_ready, tx_valid, tx_data, busy, grant_id, abort} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_held: got %h expected %h", {req_ready, tx_valid, tx_data, busy, grant_id, abort}, 18'h0);
    end
    rst = 1'b0;
    req_valid = '0;
    req_last = '0;
    tick;
    n_tests++;
    if ({busy, grant_id, tx_valid} !== 5'h0) begin
      n_fail++;
      $display("FAIL reset_release: got %h expected %h", {busy, grant_id, tx_valid}, 5'h0);
    end
  endtask
  task automatic test_single;
    logic [7:0] ex [4] = '{8'hA2, 8'h11, 8'h22, 8'h33};
    do_reset;
    req_valid = 4'b0100;
    req_data[23:16] = 8'h11;
    #1;
    n_tests++;
    if ({tx_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_arb_cycle: got %b expected 00", {tx_valid, busy});
    end
    for (int j = 0; j < 4; j++) begin
      tick;
      if (j > 0) begin
        req_data[23:16] = ex[j];
        req_last[2] = j == 3;
      end
      #1;
      n_tests++;
      if ({tx_valid, tx_data, busy, req_ready} !== {1'b1, ex[j], 1'b1, (j == 0 ? 4'b0000 : 4'b0100)}) begin
        n_fail++;
        $display("FAIL single_byte%0d: got %h expected %h", j, {tx_valid, tx_data, busy, req_ready},
                 {1'b1, ex[j], 1'b1, (j == 0 ? 4'b0000 : 4'b0100)});
      end
    end
    tick;
    req_valid = '0;
    req_last = '0;
    #1;
    n_tests++;
    if ({busy, grant_id} !== {1'b0, 3'd2}) begin
      n_fail++;
      $display("FAIL single_end: got %h expected %h", {busy, grant_id}, {1'b0, 3'd2});
    end
  endtask
  task automatic test_round_robin;
    logic [2:0] id;
    do_reset;
    req_data = 32'hD3D2D1D0;
    req_last = 4'hF;
    req_valid = 4'hF;
    for (int p = 0; p < 6; p++) begin
      id = 3'(p % 4);
      #1;
      n_tests++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_idle%0d: got busy=%b expected 0", p, busy);
      end
      tick;
      n_tests++;
      if ({grant_id, tx_data} !== {id, 8'hA0 | 8'(id)}) begin
        n_fail++;
        $display("FAIL rr_hdr%0d: got %h expected %h", p, {grant_id, tx_data}, {id, 8'hA0 | 8'(id)});
      end
      tick;
      n_tests++;
      if ({req_ready, tx_data} !== {4'(1 << id), 8'hD0 | 8'(id)}) begin
        n_fail++;
        $display("FAIL rr_data%0d: got %h expected %h", p, {req_ready, tx_data}, {4'(1 << id), 8'hD0 | 8'(id)});
      end
      tick;
    end
    req_valid = '0;
  endtask
  task automatic test_packet_lock;
    do_reset;
    req_valid = 4'b0011;
    req_last = 4'b0010;
    req_data[7:0] = 8'h01;
    req_data[15:8] = 8'hB1;
    tick;
    n_tests++;
    if ({grant_id, req_ready, tx_data} !== {3'd0, 4'b0000, 8'hA0}) begin
      n_fail++;
      $display("FAIL lock_hdr: got %h expected %h", {grant_id, req_ready, tx_data}, {3'd0, 4'b0000, 8'hA0});
    end
    for (int j = 0; j < 4; j++) begin
      tick;
      req_data[7:0] = 8'(j + 1);
      req_last[0] = j == 3;
      #1;
      n_tests++;
      if ({req_ready, tx_data} !== {4'b0001, 8'(j + 1)}) begin
        n_fail++;
        $display("FAIL lock_byte%0d: got %h expected %h", j, {req_ready, tx_data}, {4'b0001, 8'(j + 1)});
      end
    end
    tick;
    req_valid[0] = 1'b0;
    req_last[0] = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_release: got busy=%b expected 0", busy);
    end
    tick;
    n_tests++;
    if ({grant_id, tx_data, req_ready} !== {3'd1, 8'hA1, 4'b0000}) begin
      n_fail++;
      $display("FAIL lock_next_hdr: got %h expected %h", {grant_id, tx_data, req_ready}, {3'd1, 8'hA1, 4'b0000});
    end
    tick;
    n_tests++;
    if ({req_ready, tx_data} !== {4'b0010, 8'hB1}) begin
      n_fail++;
      $display("FAIL lock_next_data: got %h expected %h", {req_ready, tx_data}, {4'b0010, 8'hB1});
    end
    tick;
    req_valid = '0;
    req_last = '0;
  endtask
  task automatic test_backpressure;
    logic       tr  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] dat [5] = '{8'h55, 8'h55, 8'h66, 8'h66, 8'h66};
    logic       lst [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] ex  [5] = '{8'hA1, 8'h55, 8'h66, 8'h66, 8'h66};
    logic [3:0] rdy [5] = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0010};
    int xfers = 0;
    do_reset;
    req_valid = 4'b0010;
    req_data[15:8] = 8'h55;
    for (int c = 0; c < 5; c++) begin
      tick;
      req_data[15:8] = dat[c];
      req_last[1] = lst[c];
      tx_ready = tr[c];
      #1;
      n_tests++;
      if ({tx_valid, tx_data, req_ready, abort, busy} !== {1'b1, ex[c], rdy[c], 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL bp_cycle%0d: got %h expected %h", c, {tx_valid, tx_data, req_ready, abort, busy},
                 {1'b1, ex[c], rdy[c], 1'b0, 1'b1});
      end
      if (tx_valid && tx_ready) xfers++;
    end
    tick;
    tx_ready = 1'b1;
    req_valid = '0;
    req_last = '0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || xfers != 3) begin
      n_fail++;
      $display("FAIL bp_done: got busy=%b xfers=%0d expected busy=0 xfers=3", busy, xfers);
    end
  endtask
  task automatic test_watchdog;
    do_reset;
    req_valid = 4'b1000;
    req_data[31:24] = 8'h3C;
    tick;
    n_tests++;
    if ({grant_id, tx_data} !== {3'd3, 8'hA3}) begin
      n_fail++;
      $display("FAIL wd_hdr: got %h expected %h", {grant_id, tx_data}, {3'd3, 8'hA3});
    end
    tick;
    n_tests++;
    if ({req_ready, tx_data} !== {4'b1000, 8'h3C}) begin
      n_fail++;
      $display("FAIL wd_byte: got %h expected %h", {req_ready, tx_data}, {4'b1000, 8'h3C});
    end
    tick;
    req_valid = 4'b0001;
    req_data[7:0] = 8'h77;
    req_last = 4'b0001;
    #1;
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) tick;
      n_tests++;
      if ({abort, busy, req_ready, tx_valid} !== {k == 16, 1'b1, 4'b1000, 1'b0}) begin
        n_fail++;
        $display("FAIL wd_stall%0d: got %b expected %b", k, {abort, busy, req_ready, tx_valid},
                 {k == 16, 1'b1, 4'b1000, 1'b0});
      end
    end
    tick;
    n_tests++;
    if ({busy, abort} !== 2'b00) begin
      n_fail++;
      $display("FAIL wd_idle: got %b expected 00", {busy, abort});
    end
    tick;
    n_tests++;
    if ({grant_id, tx_data} !== {3'd0, 8'hA0}) begin
      n_fail++;
      $display("FAIL wd_next_hdr: got %h expected %h", {grant_id, tx_data}, {3'd0, 8'hA0});
    end
    tick;
    n_tests++;
    if ({req_ready, tx_data} !== {4'b0001, 8'h77}) begin
      n_fail++;
      $display("FAIL wd_next_data: got %h expected %h", {req_ready, tx_data}, {4'b0001, 8'h77});
    end
    tick;
    req_valid = '0;
    req_last = '0;
  endtask
  task automatic test_reset_mid;
    do_reset;
    req_valid = 4'b0010;
    req_data[15:8] = 8'h5A;
    tick;
    tick;
    req_valid = 4'b1011;
    #1;
    n_tests++;
    if ({tx_valid, busy, grant_id, tx_data} !== {1'b1, 1'b1, 3'd1, 8'h5A}) begin
      n_fail++;
      $display("FAIL mid_data: got %h expected %h", {tx_valid, busy, grant_id, tx_data}, {1'b1, 1'b1, 3'd1, 8'h5A});
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({req_ready, tx_valid, tx_data, busy, grant_id, abort} !== 18'h0) begin
      n_fail++;
      $display("FAIL mid_reset: got %h expected %h", {req_ready, tx_valid, tx_data, busy, grant_id, abort}, 18'h0);
    end
    tick;
    rst = 1'b0;
    req_valid = 4'b1001;
    #1;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_idle: got busy=%b expected 0", busy);
    end
    tick;
    n_tests++;
    if ({grant_id, tx_data} !== {3'd0, 8'hA0}) begin
      n_fail++;
      $display("FAIL mid_regrant: got %h expected %h", {grant_id, tx_data}, {3'd0, 8'hA0});
    end
    req_valid = '0;
  endtask
  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_packet_lock;
    test_backpressure;
    test_watchdog;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
